// File: rtl/rv32_ahb_lite_sram_slave_pkg.sv
// Shared types and constants for the AHB-Lite SRAM slave: bus encodings,
// slave response FSM states and byte-lane helper functions.
package rv32_ahb_lite_sram_slave_pkg;

   typedef enum logic [1:0] {
      S_OKAY = 2'd0,
      S_WAIT = 2'd1,
      S_ERR1 = 2'd2,
      S_ERR2 = 2'd3
   } ahb_slv_state_t;

   localparam logic       AHB_RESP_OKAY  = 1'b0;
   localparam logic       AHB_RESP_ERROR = 1'b1;

   localparam logic [1:0] AHB_IDLE   = 2'b00;
   localparam logic [1:0] AHB_BUSY   = 2'b01;
   localparam logic [1:0] AHB_NONSEQ = 2'b10;

   localparam logic [2:0] AHB_SIZE_BYTE = 3'd0;
   localparam logic [2:0] AHB_SIZE_HALF = 3'd1;
   localparam logic [2:0] AHB_SIZE_WORD = 3'd2;

   // NONSEQ and SEQ both carry a real transfer; SEQ is handled as NONSEQ.
   function automatic logic ahb_trans_valid(input logic [1:0] htrans);
      return (htrans != AHB_IDLE) && (htrans != AHB_BUSY);
   endfunction

   // Half uses only lsb[1] and word ignores lsb, which also gives the forced
   // alignment behaviour when misaligned accesses are not flagged as errors.
   function automatic logic [3:0] ahb_byte_en(input logic [2:0] size, input logic [1:0] lsb);
      case (size)
         AHB_SIZE_BYTE: return 4'b0001 << lsb;
         AHB_SIZE_HALF: return 4'b0011 << {lsb[1], 1'b0};
         default:       return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] base,
                                              input logic [31:0] over,
                                              input logic [3:0]  mask);
      logic [31:0] r;
      r = base;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) r[8*i +: 8] = over[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/rv32_ahb_lite_sram_slave_sram.sv
// Behavioural single-port synchronous-read SRAM with byte write-enables;
// stands in for the hard macro. A write cycle leaves rdata unchanged.
module rv32_sram_sp #(
   parameter int DEPTH = 4096
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic [3:0]               we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (|we) begin
            for (int i = 0; i < 4; i++) begin
               if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/rv32_ahb_lite_sram_slave.sv
// AHB-Lite slave in front of the on-chip SRAM: pipelined single transfers,
// WAIT_STATES wait cycles, read-after-write forwarding. Define AHB_SRAM_ERR_EN for ERROR responses.
module rv32_ahb_lite_sram_slave
   import rv32_ahb_lite_sram_slave_pkg::*;
#(
   parameter int MEM_BYTES   = 16384,
   parameter int WAIT_STATES = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           HSEL,
   input  logic [31:0]    HADDR,
   input  logic [1:0]     HTRANS,
   input  logic           HWRITE,
   input  logic [2:0]     HSIZE,
   input  logic [31:0]    HWDATA,
   input  logic           HREADY,
   output logic           HREADYOUT,
   output logic           HRESP,
   output logic [31:0]    HRDATA,
   output ahb_slv_state_t dbg_state
);

   localparam int         AW        = $clog2(MEM_BYTES);
   localparam int         DEPTH     = MEM_BYTES / 4;
   localparam int         WW        = AW - 2;
   localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

   ahb_slv_state_t state_q, state_d;
   logic [2:0]     wcnt_q, wcnt_d;

   logic           accept, xfer_ok, rd_issue;
   logic [WW-1:0]  a_word;
   logic [3:0]     a_be;

   logic           dp_valid, dp_write;
   logic [3:0]     dp_be;
   logic [WW-1:0]  dp_word;
   logic           data_end, commit_now;

   logic           pend_valid;
   logic [WW-1:0]  pend_word;
   logic [3:0]     pend_be;
   logic [31:0]    pend_data;

   logic [3:0]     fwd_mask_q, fwd_mask_d;
   logic [31:0]    fwd_data_q, fwd_data_d;

   logic           ram_en;
   logic [3:0]     ram_we;
   logic [WW-1:0]  ram_addr;
   logic [31:0]    ram_wdata, ram_rdata;
   logic [31:0]    merged, rdata_q;

   assign accept = HSEL & HREADY & ahb_trans_valid(HTRANS);
   assign a_word = HADDR[AW-1:2];
   assign a_be   = ahb_byte_en(HSIZE, HADDR[1:0]);

`ifdef AHB_SRAM_ERR_EN
   logic addr_err;
   assign addr_err = (HADDR[31:AW] != '0) | (HSIZE > AHB_SIZE_WORD)
                   | ((HSIZE == AHB_SIZE_HALF) & HADDR[0])
                   | ((HSIZE == AHB_SIZE_WORD) & (|HADDR[1:0]));
   assign xfer_ok = accept & ~addr_err;
`else
   // Upper address bits are dropped so the array aliases modulo MEM_BYTES.
   logic unused_hi;
   assign unused_hi = ^HADDR[31:AW];
   assign xfer_ok   = accept;
`endif

   assign rd_issue   = xfer_ok & ~HWRITE;
   assign data_end   = dp_valid & (state_q == S_OKAY);
   assign commit_now = data_end & dp_write;

   // Response FSM
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      HREADYOUT = 1'b1;
      HRESP     = AHB_RESP_OKAY;
      case (state_q)
         S_WAIT: begin
            HREADYOUT = 1'b0;
            wcnt_d    = wcnt_q - 3'd1;
            if (wcnt_q <= 3'd1) state_d = S_OKAY;
         end
`ifdef AHB_SRAM_ERR_EN
         S_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = AHB_RESP_ERROR;
            state_d   = S_ERR2;
         end
`endif
         default: begin
            // OKAY and ERR2 both end a data phase and may take a new address phase.
            state_d = S_OKAY;
`ifdef AHB_SRAM_ERR_EN
            if (state_q == S_ERR2) HRESP = AHB_RESP_ERROR;
            if (accept && addr_err) state_d = S_ERR1;
            else
`endif
            if (accept && WAIT_STATES > 0) begin
               state_d = S_WAIT;
               wcnt_d  = WAIT_LOAD;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_OKAY;
         wcnt_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   assign dbg_state = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_be    <= 4'b0;
         dp_word  <= '0;
      end else if (accept) begin
         dp_valid <= xfer_ok;
         dp_write <= HWRITE;
         dp_be    <= a_be;
         dp_word  <= a_word;
      end else if (data_end) begin
         dp_valid <= 1'b0;
      end
   end

   // A write ending on the same edge a read is issued is parked here and
   // committed on the next edge with no read, so the single port never serves both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid <= 1'b0;
         pend_word  <= '0;
         pend_be    <= 4'b0;
         pend_data  <= 32'b0;
      end else if (rd_issue && commit_now) begin
         pend_valid <= 1'b1;
         pend_word  <= dp_word;
         pend_be    <= dp_be;
         pend_data  <= HWDATA;
      end else if (!rd_issue && !commit_now) begin
         pend_valid <= 1'b0;
      end
   end

   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 4'b0;
      ram_addr  = a_word;
      ram_wdata = HWDATA;
      if (rd_issue) begin
         ram_en = 1'b1;
      end else if (commit_now) begin
         ram_en   = 1'b1;
         ram_we   = dp_be;
         ram_addr = dp_word;
      end else if (pend_valid) begin
         ram_en    = 1'b1;
         ram_we    = pend_be;
         ram_addr  = pend_word;
         ram_wdata = pend_data;
      end
   end

   // Lanes a read must take from in-flight writes rather than the array.
   always_comb begin
      fwd_mask_d = 4'b0;
      fwd_data_d = 32'b0;
      if (pend_valid && pend_word == a_word) begin
         fwd_mask_d = pend_be;
         fwd_data_d = pend_data;
      end
      if (commit_now && dp_word == a_word) begin
         fwd_mask_d = fwd_mask_d | dp_be;
         fwd_data_d = lane_merge(fwd_data_d, HWDATA, dp_be);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_mask_q <= 4'b0;
         fwd_data_q <= 32'b0;
      end else if (rd_issue) begin
         fwd_mask_q <= fwd_mask_d;
         fwd_data_q <= fwd_data_d;
      end
   end

   rv32_sram_sp #(.DEPTH(DEPTH)) u_sram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   assign merged = lane_merge(ram_rdata, fwd_data_q, fwd_mask_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     rdata_q <= 32'b0;
      else if (data_end && !dp_write) rdata_q <= merged;
   end

   assign HRDATA = (data_end && !dp_write) ? merged : rdata_q;

endmodule

// File: tb/tb_rv32_ahb_lite_sram_slave.sv
// Bench for rv32_ahb_lite_sram_slave: one instance with zero wait states and
// one with three, driven in turn over a shared bus with a queue-based response monitor.
module tb_rv32_ahb_lite_sram_slave;
   import rv32_ahb_lite_sram_slave_pkg::*;

   localparam int MEM_BYTES = 16384;

   logic           clk, rst_n;
   logic           hsel0, hsel3, hwrite;
   logic [31:0]    haddr, hwdata;
   logic [1:0]     htrans;
   logic [2:0]     hsize;
   logic           hreadyout0, hresp0, hreadyout3, hresp3;
   logic [31:0]    hrdata0, hrdata3;
   ahb_slv_state_t dbg0, dbg3;

   bit             cur;
   logic           ro_cur, resp_cur, hsel_cur;
   logic [31:0]    rdata_cur;

   int             n_tests = 0;
   int             n_fail  = 0;
   int             n_pop   = 0;
   // {wait_cycles[2:0], resp, is_read, data[31:0]}
   logic [36:0]    exp_q[$];

   assign ro_cur    = cur ? hreadyout3 : hreadyout0;
   assign resp_cur  = cur ? hresp3 : hresp0;
   assign rdata_cur = cur ? hrdata3 : hrdata0;
   assign hsel_cur  = cur ? hsel3 : hsel0;

   rv32_ahb_lite_sram_slave #(.MEM_BYTES(MEM_BYTES), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hreadyout0),
      .HREADYOUT(hreadyout0), .HRESP(hresp0), .HRDATA(hrdata0), .dbg_state(dbg0)
   );

   rv32_ahb_lite_sram_slave #(.MEM_BYTES(MEM_BYTES), .WAIT_STATES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hreadyout3),
      .HREADYOUT(hreadyout3), .HRESP(hresp3), .HRDATA(hrdata3), .dbg_state(dbg3)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // driver: one address phase, data phase follows while the next call drives its address
   task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic [31:0] exp_data,
                       input bit exp_err, input bit push);
      int n;
      logic [2:0] waits;
      hsel0  = (cur == 1'b0);
      hsel3  = (cur == 1'b1);
      htrans = AHB_NONSEQ;
      haddr  = addr;
      hwrite = wr;
      hsize  = size;
      n = 0;
      @(negedge clk);
      while (!ro_cur && n < 32) begin
         @(negedge clk);
         n++;
      end
      if (!ro_cur) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: addr 0x%08h never accepted", addr);
      end
      @(posedge clk);
      #1;
      hwdata = wdata;
      waits  = exp_err ? 3'd1 : (cur ? 3'd3 : 3'd0);
      if (push) exp_q.push_back({waits, exp_err, ~wr & ~exp_err, exp_data});
      hsel0  = 1'b0;
      hsel3  = 1'b0;
      htrans = AHB_IDLE;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
      xfer(1'b1, addr, size, data, 32'h0, 1'b0, 1'b1);
   endtask

   task automatic rd(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] exp);
      xfer(1'b0, addr, size, 32'h0, exp, 1'b0, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("drain_queue", exp_q.size(), 0);
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin : monitor
      logic       in_dp;
      int         low_cnt;
      logic [36:0] e;
      if (!rst_n) begin
         in_dp   = 1'b0;
         low_cnt = 0;
      end else begin
         if (in_dp) begin
            if (ro_cur) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_rsp: data phase with no expected entry");
               end else begin
                  e = exp_q.pop_front();
                  n_pop++;
                  chk($sformatf("hresp#%0d", n_pop), 32'(resp_cur), 32'(e[33]));
                  chk($sformatf("wait_cycles#%0d", n_pop), low_cnt, 32'(e[36:34]));
                  if (e[32]) chk($sformatf("hrdata#%0d", n_pop), rdata_cur, e[31:0]);
               end
               in_dp   = 1'b0;
               low_cnt = 0;
            end else begin
               low_cnt++;
            end
         end
         if (hsel_cur && ro_cur && htrans[1]) begin
            in_dp   = 1'b1;
            low_cnt = 0;
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      cur    = 1'b0;
      hsel0  = 1'b0;
      hsel3  = 1'b0;
      htrans = AHB_IDLE;
      haddr  = 32'h0;
      hwrite = 1'b0;
      hsize  = AHB_SIZE_WORD;
      hwdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hreadyout0", 32'(hreadyout0), 32'd1);
      chk("rst_hresp0",     32'(hresp0),     32'd0);
      chk("rst_hrdata0",    hrdata0,         32'h0);
      chk("rst_hreadyout3", 32'(hreadyout3), 32'd1);
      chk("rst_hresp3",     32'(hresp3),     32'd0);
      chk("rst_hrdata3",    hrdata3,         32'h0);
      rst_n = 1'b1;
      idle(1);

      // zero-wait instance
      cur = 1'b0;
      wr(32'h10, AHB_SIZE_WORD, 32'hDEADBEEF);  idle(1);
      rd(32'h10, AHB_SIZE_WORD, 32'hDEADBEEF);  idle(1);
      wr(32'h10, AHB_SIZE_WORD, 32'h11223344);  idle(1);
      wr(32'h13, AHB_SIZE_BYTE, 32'hAA000000);  idle(1);
      rd(32'h10, AHB_SIZE_WORD, 32'hAA223344);  idle(1);
      wr(32'h20, AHB_SIZE_WORD, 32'h12345678);
      rd(32'h20, AHB_SIZE_WORD, 32'h12345678);  idle(1);
      wr(32'h24, AHB_SIZE_WORD, 32'hCAFEF00D);  idle(1);
      wr(32'h25, AHB_SIZE_BYTE, 32'h00005500);
      rd(32'h24, AHB_SIZE_WORD, 32'hCAFE550D);  idle(1);
      wr(32'h28, AHB_SIZE_WORD, 32'h01020304);
      rd(32'h10, AHB_SIZE_WORD, 32'hAA223344);
      rd(32'h28, AHB_SIZE_WORD, 32'h01020304);  idle(2);
      rd(32'h28, AHB_SIZE_WORD, 32'h01020304);  idle(1);
      wr(32'h22, AHB_SIZE_HALF, 32'hBEEF0000);  idle(1);
      rd(32'h20, AHB_SIZE_WORD, 32'hBEEF5678);  idle(1);
      wr(32'h00, AHB_SIZE_WORD, 32'h11111111);  idle(1);
`ifdef AHB_SRAM_ERR_EN
      xfer(1'b0, MEM_BYTES, AHB_SIZE_WORD, 32'h0, 32'h0, 1'b1, 1'b1);
      xfer(1'b1, 32'h01, AHB_SIZE_HALF, 32'h0000BBBB, 32'h0, 1'b1, 1'b1);
      xfer(1'b0, 32'h00, 3'd3, 32'h0, 32'h0, 1'b1, 1'b1);  idle(1);
      rd(32'h00, AHB_SIZE_WORD, 32'h11111111);  idle(1);
`else
      rd(MEM_BYTES, AHB_SIZE_WORD, 32'h11111111);  idle(1);
      wr(32'h01, AHB_SIZE_HALF, 32'h0000BBBB);     idle(1);
      rd(32'h00, 3'd3, 32'h1111BBBB);              idle(1);
`endif
      drain();

      // three-wait instance
      cur = 1'b1;
      wr(32'h04, AHB_SIZE_WORD, 32'h0BADF00D);
      rd(32'h04, AHB_SIZE_WORD, 32'h0BADF00D);  idle(1);
`ifdef AHB_SRAM_ERR_EN
      xfer(1'b0, 32'h06, AHB_SIZE_WORD, 32'h0, 32'h0, 1'b1, 1'b1);  idle(1);
`else
      rd(32'h06, AHB_SIZE_WORD, 32'h0BADF00D);  idle(1);
`endif
      wr(32'h0C, AHB_SIZE_WORD, 32'h13579BDF);
      rd(32'h0C, AHB_SIZE_WORD, 32'h13579BDF);  idle(1);
      wr(32'h08, AHB_SIZE_WORD, 32'hA5A5A5A5);  idle(5);
      rd(32'h08, AHB_SIZE_WORD, 32'hA5A5A5A5);
      drain();

      // abort a write while it is stalled in its wait states
      xfer(1'b1, 32'h08, AHB_SIZE_WORD, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
      idle(1);
      rst_n = 1'b0;
      #1;
      chk("midrst_hreadyout3", 32'(hreadyout3), 32'd1);
      chk("midrst_hresp3",     32'(hresp3),     32'd0);
      chk("midrst_hrdata3",    hrdata3,         32'h0);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      rd(32'h08, AHB_SIZE_WORD, 32'hA5A5A5A5);  idle(1);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
